// File: rtl/icache_sa.sv
// icache_sa: set-associative (1- or 2-way) instruction cache with a 48-bit fetch window.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   adr_i, stb_i      halfword-aligned fetch address and request
//   flush_i           invalidate all lines
//   hit_o             halfwords at adr_i, adr_i+2 and adr_i+4 are all resident
//   inst_o, data_o    halfword at adr_i; {halfword at adr_i+2, halfword at adr_i+4}
//   busy_o, err_o     line fill in progress; one-cycle pulse when a fill hits a bus error
//   wb_*              Wishbone master used to fill one line, one halfword per beat
module icache_sa #(
    parameter int unsigned SET_BITS  = 8,
    parameter int unsigned LINE_BITS = 5,
    parameter int unsigned WAYS      = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] adr_i,
    input  logic        stb_i,
    input  logic        flush_i,
    output logic        hit_o,
    output logic [15:0] inst_o,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [31:0] wb_adr_o,
    input  logic [15:0] wb_dat_i,
    output logic [1:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int unsigned SETS  = 1 << SET_BITS;
    localparam int unsigned HWS   = 1 << (LINE_BITS - 1);
    localparam int unsigned TAG_W = 32 - SET_BITS - LINE_BITS;
    localparam int unsigned OFF_W = LINE_BITS - 1;

    typedef enum logic [1:0] {StIdle, StFill, StFillDone} state_e;

    state_e              state_q, state_d;
    logic [TAG_W-1:0]    fill_tag_q, fill_tag_d;
    logic [SET_BITS-1:0] fill_set_q, fill_set_d;
    logic                fill_way_q, fill_way_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [31:0]         wb_adr_q, wb_adr_d;
    logic                wb_stb_q, wb_stb_d;
    logic                err_q, err_d;
    logic                flush_pend_q, flush_pend_d;
    logic [SETS-1:0]     valid_q [WAYS];
    logic [SETS-1:0]     valid_d [WAYS];
    logic [SETS-1:0]     lru_q, lru_d;   // per set: way to evict next
    logic [TAG_W-1:0]    tag_q [WAYS][SETS];
    logic [15:0]         data_q [WAYS][SETS][HWS];
    logic                data_we, tag_we;

    // Address decode for lineA (adr_i) and lineB (adr_i+4, full 32-bit wrap)
    logic [31:0]         adr_b;
    logic [TAG_W-1:0]    tag_a, tag_b;
    logic [SET_BITS-1:0] set_a, set_b;
    logic [OFF_W-1:0]    off_a, off_a_nxt, off_b;
    logic                unused_bits;

    assign adr_b       = adr_i + 32'd4;
    assign tag_a       = adr_i[31:SET_BITS+LINE_BITS];
    assign tag_b       = adr_b[31:SET_BITS+LINE_BITS];
    assign set_a       = adr_i[SET_BITS+LINE_BITS-1:LINE_BITS];
    assign set_b       = adr_b[SET_BITS+LINE_BITS-1:LINE_BITS];
    assign off_a       = adr_i[LINE_BITS-1:1];
    assign off_b       = adr_b[LINE_BITS-1:1];
    assign off_a_nxt   = off_a + OFF_W'(1);
    assign unused_bits = ^{adr_i[0], adr_b[0]};

    logic hit_a, hit_b, way_a, way_b;

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        way_a = 1'b0;
        way_b = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[w][set_a] && tag_q[w][set_a] == tag_a) begin
                hit_a = 1'b1;
                way_a = 1'(w);
            end
            if (valid_q[w][set_b] && tag_q[w][set_b] == tag_b) begin
                hit_b = 1'b1;
                way_b = 1'(w);
            end
        end
    end

    assign hit_o = ~rst_i & hit_a & hit_b;

    // adr_i+2 falls in lineB only when adr_i is the last halfword of lineA
    logic [15:0] mid_hw;
    always_comb begin
        inst_o = data_q[way_a][set_a][off_a];
        if (&off_a) begin
            mid_hw = data_q[way_b][set_b][0];
        end else begin
            mid_hw = data_q[way_a][set_a][off_a_nxt];
        end
        data_o = {mid_hw, data_q[way_b][set_b][off_b]};
    end

    // Fill target: lineA if it misses, otherwise lineB
    logic [SET_BITS-1:0] tgt_set;
    logic [TAG_W-1:0]    tgt_tag;
    logic [31:0]         tgt_base;
    logic                victim, vic_found;

    always_comb begin
        tgt_set  = hit_a ? set_b : set_a;
        tgt_tag  = hit_a ? tag_b : tag_a;
        tgt_base = hit_a ? {adr_b[31:LINE_BITS], {LINE_BITS{1'b0}}}
                         : {adr_i[31:LINE_BITS], {LINE_BITS{1'b0}}};
        victim    = lru_q[tgt_set];
        vic_found = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!vic_found && !valid_q[w][tgt_set]) begin
                victim    = 1'(w);
                vic_found = 1'b1;
            end
        end
        if (WAYS == 1) begin
            victim = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        fill_tag_d   = fill_tag_q;
        fill_set_d   = fill_set_q;
        fill_way_d   = fill_way_q;
        off_d        = off_q;
        wb_adr_d     = wb_adr_q;
        wb_stb_d     = wb_stb_q;
        err_d        = 1'b0;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q;
        lru_d        = lru_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;

        if (stb_i && hit_o) begin
            lru_d[set_a] = ~way_a;
        end

        unique case (state_q)
            StIdle: begin
                if (flush_i) begin
                    for (int unsigned w = 0; w < WAYS; w++) valid_d[w] = '0;
                end else if (stb_i && !hit_o) begin
                    fill_tag_d = tgt_tag;
                    fill_set_d = tgt_set;
                    fill_way_d = victim;
                    off_d      = '0;
                    wb_adr_d   = tgt_base;
                    wb_stb_d   = 1'b1;
                    // The victim is overwritten beat by beat, so it must stop hitting now
                    valid_d[victim][tgt_set] = 1'b0;
                    state_d    = StFill;
                end
            end
            StFill: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (wb_err_i) begin
                    wb_stb_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = StIdle;
                    if (flush_pend_q || flush_i) begin
                        for (int unsigned w = 0; w < WAYS; w++) valid_d[w] = '0;
                        flush_pend_d = 1'b0;
                    end
                end else if (wb_ack_i) begin
                    data_we  = 1'b1;
                    wb_adr_d = wb_adr_q + 32'd2;
                    off_d    = off_q + OFF_W'(1);
                    if (&off_q) begin
                        wb_stb_d = 1'b0;
                        state_d  = StFillDone;
                    end
                end
            end
            StFillDone: begin
                if (flush_pend_q || flush_i) begin
                    for (int unsigned w = 0; w < WAYS; w++) valid_d[w] = '0;
                    flush_pend_d = 1'b0;
                end else begin
                    tag_we = 1'b1;
                    valid_d[fill_way_q][fill_set_q] = 1'b1;
                end
                lru_d[fill_set_q] = ~fill_way_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            fill_tag_q   <= '0;
            fill_set_q   <= '0;
            fill_way_q   <= 1'b0;
            off_q        <= '0;
            wb_adr_q     <= '0;
            wb_stb_q     <= 1'b0;
            err_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            lru_q        <= '0;
            for (int unsigned w = 0; w < WAYS; w++) valid_q[w] <= '0;
        end else begin
            state_q      <= state_d;
            fill_tag_q   <= fill_tag_d;
            fill_set_q   <= fill_set_d;
            fill_way_q   <= fill_way_d;
            off_q        <= off_d;
            wb_adr_q     <= wb_adr_d;
            wb_stb_q     <= wb_stb_d;
            err_q        <= err_d;
            flush_pend_q <= flush_pend_d;
            lru_q        <= lru_d;
            valid_q      <= valid_d;
        end
    end

    // Tag and data storage carry no reset; valid bits qualify them
    always_ff @(posedge clk_i) begin
        if (data_we) begin
            data_q[fill_way_q][fill_set_q][off_q] <= wb_dat_i;
        end
        if (tag_we) begin
            tag_q[fill_way_q][fill_set_q] <= fill_tag_q;
        end
    end

    assign wb_adr_o = wb_adr_q;
    assign wb_stb_o = wb_stb_q;
    assign wb_cyc_o = wb_stb_q;
    assign wb_sel_o = 2'b11;
    assign busy_o   = (state_q != StIdle);
    assign err_o    = err_q;

endmodule
